// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds the FSM state encoding, load/store width codes and the request error rule.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  // Load widths; stores reuse the same encodings.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = LB;
  localparam logic [2:0] SH  = LH;
  localparam logic [2:0] SW  = LW;

  typedef logic req_idx_t;
  localparam req_idx_t REQ_CORE = 1'b0;
  localparam req_idx_t REQ_DBG  = 1'b1;

  // Width/alignment part of the error rule; the range check needs LEN and lives in the top.
  function automatic logic f3_error(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic err;
    unique case (funct3)
      LB, LBU: err = 1'b0;
      LH, LHU: err = addr_lo[0];
      LW:      err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, under contention the
// requester that did not win last time wins. History only moves on acceptance.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant
);

  req_idx_t last_grant;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves grant unassigned (no latch).
    grant = REQ_CORE;
    if (valid0 && valid1) begin
      grant = (last_grant == REQ_CORE) ? REQ_DBG : REQ_CORE;
    end else if (valid1) begin
      grant = REQ_DBG;
    end
  end

  // NOTE: clocked state uses <= so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_DBG;  // core wins the first contention after reset
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the core load/store port and the debug/loader port onto one DMem.
// Every accepted request takes ISSUE then RESP, giving a fixed 2-cycle latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int W   = 32,
  parameter int LEN = 100
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_valid,
  input  logic         req0_write,
  input  logic [2:0]   req0_funct3,
  input  logic [W-1:0] req0_addr,
  input  logic [W-1:0] req0_wdata,
  output logic         req0_ready,

  input  logic         req1_valid,
  input  logic         req1_write,
  input  logic [2:0]   req1_funct3,
  input  logic [W-1:0] req1_addr,
  input  logic [W-1:0] req1_wdata,
  output logic         req1_ready,

  output logic         resp0_valid,
  output logic         resp0_err,
  output logic [W-1:0] resp0_rdata,
  output logic         resp1_valid,
  output logic         resp1_err,
  output logic [W-1:0] resp1_rdata,

  output logic [W-1:0] mem_addr,
  output logic [2:0]   mem_funct3,
  output logic [W-1:0] mem_wdata,
  output logic         mem_MemRead,
  output logic         mem_MemWrite,
  input  logic [W-1:0] mem_rdata,

  output logic         core_stall
);

  localparam logic [W-1:0] ADDR_LIMIT = W'(4 * LEN);

  state_t   state;
  req_idx_t r_idx;
  logic     r_write;
  logic     r_err;

  logic     grant;
  logic     can_accept;
  logic     accept;

  logic         sel_write;
  logic [2:0]   sel_funct3;
  logic [W-1:0] sel_addr;
  logic [W-1:0] sel_wdata;
  logic         sel_err;
  logic [W-1:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Ready is combinational on valid so a request can be taken in the cycle it appears.
  assign can_accept = !reset && (state == IDLE || state == RESP);
  assign accept     = can_accept && (req0_valid || req1_valid);
  assign req0_ready = accept && (grant == REQ_CORE);
  assign req1_ready = accept && (grant == REQ_DBG);
  assign core_stall = req0_valid && !req0_ready;

  assign sel_write  = (grant == REQ_DBG) ? req1_write  : req0_write;
  assign sel_funct3 = (grant == REQ_DBG) ? req1_funct3 : req0_funct3;
  assign sel_addr   = (grant == REQ_DBG) ? req1_addr   : req0_addr;
  assign sel_wdata  = (grant == REQ_DBG) ? req1_wdata  : req0_wdata;
  assign sel_err    = f3_error(sel_funct3, sel_addr[1:0]) || (sel_addr >= ADDR_LIMIT);

  // Writes and rejected requests return zero data.
  assign resp_data  = (r_err || r_write) ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      r_idx        <= REQ_CORE;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      mem_addr     <= '0;
      mem_funct3   <= '0;
      mem_wdata    <= '0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      resp0_valid  <= 1'b0;
      resp0_err    <= 1'b0;
      resp0_rdata  <= '0;
      resp1_valid  <= 1'b0;
      resp1_err    <= 1'b0;
      resp1_rdata  <= '0;
    end else begin
      // Memory command and response are one-cycle pulses; idle value is all zeros.
      mem_addr     <= '0;
      mem_funct3   <= '0;
      mem_wdata    <= '0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      resp0_valid  <= 1'b0;
      resp0_err    <= 1'b0;
      resp0_rdata  <= '0;
      resp1_valid  <= 1'b0;
      resp1_err    <= 1'b0;
      resp1_rdata  <= '0;

      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            state        <= ISSUE;
            r_idx        <= grant;
            r_write      <= sel_write;
            r_err        <= sel_err;
            mem_addr     <= sel_addr;
            mem_funct3   <= sel_funct3;
            mem_wdata    <= sel_wdata;
            mem_MemRead  <= !sel_write && !sel_err;
            mem_MemWrite <= sel_write && !sel_err;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state <= RESP;
          if (r_idx == REQ_CORE) begin
            resp0_valid <= 1'b1;
            resp0_err   <= r_err;
            resp0_rdata <= resp_data;
          end else begin
            resp1_valid <= 1'b1;
            resp1_err   <= r_err;
            resp1_rdata <= resp_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
